mmio_timer: RTL
===============

Name: mmio_timer

Overview:
Memory-mapped timer peripheral that sits on the CPU data bus as a responder to processor loads and stores.
- Holds a free-running 32-bit counter with a compare register, match status flag and interrupt output.
- Register writes take effect at the clock edge; reads return data in the same cycle, matching the single-cycle CPU data path.

Parameters:
PRESCALE, 1, counter advances once every PRESCALE clock cycles while enabled; legal range 1..65535.
COMPARE_RST, 32'hFFFFFFFF, reset value of the COMPARE register.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
sel  input  1  chip select from the system address decoder; qualifies we and rdata
we  input  1  store strobe; register write at the clk edge when sel & we
addr  input  2  word register index (byte address bits [3:2])
wdata  input  32  store data
rdata  output  32  load data; combinational from addr and register state
irq  output  1  interrupt request to the CPU

Behaviour:
- Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 1 COUNT: 32-bit counter.
  - 2 COMPARE: 32-bit.
  - 3 STATUS: bit0 MATCH; other bits read 0.
- Reset, immediate on reset assertion regardless of clk:
  - CTRL=0, COUNT=0, COMPARE=COMPARE_RST, MATCH=0, prescaler=0.
  - irq=0.
  - rdata follows the reset register values.
- Prescaler:
  - Internal 16-bit count.
  - While EN=1 it counts 0..PRESCALE-1. tick=1 in the cycle it equals PRESCALE-1, then it returns to 0.
  - While EN=0 it is held at 0 and tick=0.
  - PRESCALE=1 gives tick=1 every cycle EN=1.
- Counter, on a tick edge:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Arithmetic is modulo 2^32: 32'hFFFFFFFF wraps to 0, with no flag unless it matches COMPARE.
- Writes (sel & we):
  - CTRL takes wdata[2:0].
  - COMPARE takes wdata.
  - COUNT takes wdata; a CPU write to COUNT overrides a same-cycle tick increment/reload. The match test in that cycle still uses the pre-write COUNT.
  - STATUS is write-1-to-clear on bit0. A same-cycle match set wins over the clear, so MATCH stays 1.
  - Writing CTRL.EN=0 resets the prescaler on the next edge. COUNT holds its value.
- Reads:
  - rdata = selected register when sel=1, else 32'h0.
  - Zero latency; no wait states. we has no effect when sel=0.
- irq = MATCH & IRQ_EN. It is a pure function of registered state (glitch-free) and is level, not pulse. It deasserts the cycle after MATCH is cleared or IRQ_EN is written 0.
- Reset mid-count: all state returns to reset values at once; no pending match or tick survives.

Optional Feature:
Macro: MMIO_TIMER_ONESHOT_EN
- Defined:
  - CTRL bit3 ONESHOT becomes read/write, reset 0.
  - On a match edge with ONESHOT=1, EN is cleared in the same edge. COUNT still updates per AUTO_RELOAD and MATCH sets.
  - A same-cycle CPU CTRL write overrides the auto-clear.
- Undefined: CTRL bit3 reads 0, writes are ignored, and no auto-clear occurs.

Test Plan:
1. Reset, then read all four registers with sel=1 -> 0, 0, 32'hFFFFFFFF, 0; irq=0. Read with sel=0 -> rdata=0.
2. PRESCALE=1. Write COMPARE=5, CTRL=3'b101 -> COUNT reaches 5. On the next edge MATCH=1, COUNT=6, irq=1 one cycle after the match edge. Write STATUS=1 -> irq=0.
3. PRESCALE=4, CTRL=3'b011, COMPARE=2 -> COUNT advances every 4th cycle: 0,1,2,0,1,2…. MATCH sets on the edge where 2 reloads to 0. irq stays 0 because IRQ_EN=0.
4. Write COUNT=32'hFFFFFFFE, COMPARE=3, EN=1 -> COUNT goes FFFFFFFE, FFFFFFFF, 0, 1 with MATCH=0. MATCH=1 after COUNT=3 is ticked.
5. Collisions: STATUS write-1 in the same cycle as a match -> MATCH remains 1. COUNT write of 100 in the same cycle as a tick -> COUNT=100.
6. Assert reset asynchronously mid-count with irq=1 -> irq and all registers go to reset values without a clk edge. With MMIO_TIMER_ONESHOT_EN, CTRL=4'b1101, COMPARE=3 -> EN reads 0 after the match edge and COUNT holds at 4.

Source files
------------

// File: rtl/mmio_timer.sv
// mmio_timer -- memory-mapped 32-bit timer peripheral on the CPU data bus.
//
// The CPU sees four word registers. Stores land at the clock edge and loads
// return data combinationally in the same cycle.
//
//   addr | register | contents
//   -----+----------+--------------------------------------------------------
//   0    | CTRL     | bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bit3 ONESHOT*
//   1    | COUNT    | 32-bit up-counter, advances on each prescaler tick
//   2    | COMPARE  | 32-bit match value
//   3    | STATUS   | bit0 MATCH (write 1 to clear)
//
//   * ONESHOT exists only when MMIO_TIMER_ONESHOT_EN is defined. On a match
//     with ONESHOT=1, EN clears itself. Without the macro, bit3 reads 0 and
//     writes to it are dropped.
//
// Parameters:
//   PRESCALE    - COUNT advances once every PRESCALE enabled cycles (1..65535).
//   COMPARE_RST - reset value of COMPARE.
//
// Ports:
//   clk    - system clock, rising-edge
//   reset  - asynchronous, active-high reset
//   sel    - chip select; qualifies we and rdata
//   we     - store strobe (register write when sel & we)
//   addr   - word register index
//   wdata  - store data
//   rdata  - load data, zero when sel=0
//   irq    - level interrupt, MATCH & IRQ_EN

module mmio_timer #(
    parameter int unsigned PRESCALE    = 1,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

`ifdef MMIO_TIMER_ONESHOT_EN
    localparam int unsigned CTRL_W = 4;
`else
    localparam int unsigned CTRL_W = 3;
`endif

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_COUNT   = 2'd1;
    localparam logic [1:0] A_COMPARE = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [31:0]       count_q,   count_d;
    logic [31:0]       compare_q, compare_d;
    logic              match_q,   match_d;
    logic [15:0]       pre_q,     pre_d;

    logic wr_ctrl, wr_count, wr_compare, wr_status;
    logic en, auto_reload, irq_en;
    logic tick, hit;

    assign wr_ctrl    = sel & we & (addr == A_CTRL);
    assign wr_count   = sel & we & (addr == A_COUNT);
    assign wr_compare = sel & we & (addr == A_COMPARE);
    assign wr_status  = sel & we & (addr == A_STATUS);

    assign en          = ctrl_q[0];
    assign auto_reload = ctrl_q[1];
    assign irq_en      = ctrl_q[2];

    // The prescaler sits at 0 whenever EN is low, so tick needs no extra gating
    // beyond EN itself. hit is the match test on the pre-write COUNT.
    assign tick = en & (pre_q == PRE_LAST);
    assign hit  = tick & (count_q == compare_q);

    always_comb begin
        ctrl_d = ctrl_q;
`ifdef MMIO_TIMER_ONESHOT_EN
        if (hit && ctrl_q[3]) begin
            ctrl_d[0] = 1'b0;
        end
`endif
        // A CPU write takes priority over the one-shot auto-clear.
        if (wr_ctrl) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end
    end

    // Restart from 0 on enable so the first tick comes a full PRESCALE cycles
    // after EN rises. Clear again whenever EN is low or about to go low.
    always_comb begin
        pre_d = pre_q + 16'd1;
        if (!en || !ctrl_d[0] || tick) begin
            pre_d = 16'd0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = (hit && auto_reload) ? 32'd0 : count_q + 32'd1;
        end
        if (wr_count) begin
            count_d = wdata;
        end
    end

    assign compare_d = wr_compare ? wdata : compare_q;

    // A match set wins over a same-cycle write-1-to-clear.
    assign match_d = hit | (match_q & ~(wr_status & wdata[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= 32'd0;
            compare_q <= COMPARE_RST;
            match_q   <= 1'b0;
            pre_q     <= 16'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            pre_q     <= pre_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            unique case (addr)
                A_CTRL:    rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                A_COUNT:   rdata = count_q;
                A_COMPARE: rdata = compare_q;
                A_STATUS:  rdata = {31'd0, match_q};
                default:   rdata = 32'd0;
            endcase
        end
    end

    // Pure function of registers, so irq never glitches.
    assign irq = match_q & irq_en;

endmodule
